// File: rtl/sum_stream_arbiter.sv
// sum_stream_arbiter: round-robin sharing of one stream-summing engine among N requesters, with a result watchdog
module sum_stream_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [N*W-1:0] s_data,
  input  logic [N-1:0]   s_valid,
  input  logic [N-1:0]   s_last,
  output logic [N-1:0]   s_ready,
  output logic [W-1:0]   r_data,
  output logic           r_err,
  output logic [N-1:0]   r_valid,
  input  logic [N-1:0]   r_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           eng_in_valid,
  input  logic           eng_in_ready,
  output logic [W-1:0]   eng_s_data,
  output logic           eng_s_valid,
  input  logic           eng_s_ready,
  input  logic           eng_out_valid,
  output logic           eng_out_ready,
  input  logic [W-1:0]   eng_sum
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] rr, gi, pick;
  logic [CW-1:0] cnt;
  logic str, last_beat, accept;
  // first pending requester at or above rr, wrapping around
  always_comb begin
    pick = rr;
    for (int k = N - 1; k >= 0; k--)
      if (s_valid[(int'(rr) + k) % N]) pick = IW'((int'(rr) + k) % N);
  end
  assign str           = state == STREAM;
  assign eng_s_data    = str ? s_data[gi*W +: W] : '0;
  assign eng_s_valid   = str & s_valid[gi];
  assign s_ready       = (str && eng_s_ready) ? grant : '0;
  assign last_beat     = eng_s_valid & eng_s_ready & s_last[gi];
  assign eng_in_valid  = state == START;
  assign eng_out_ready = state == WAIT;
  assign busy          = state != IDLE;
  assign r_valid       = (state == RESP) ? grant : '0;
  assign accept        = |(r_ready & grant);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      rr     <= '0;
      gi     <= '0;
      grant  <= '0;
      cnt    <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|s_valid) begin
          gi    <= pick;
          grant <= {{(N-1){1'b0}}, 1'b1} << pick;
          state <= START;
        end
        START: if (eng_in_ready) state <= STREAM;
        STREAM: if (last_beat) begin
          cnt   <= '0;
          state <= WAIT;
        end
        // a result arriving on the expiry cycle still wins over the abort
        WAIT: if (eng_out_valid) begin
          r_data <= eng_sum;
          r_err  <= 1'b0;
          state  <= RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          r_data <= '0;
          r_err  <= 1'b1;
          state  <= RESP;
        end else cnt <= cnt + 1'b1;
        RESP: if (accept) begin
          rr    <= (gi == IW'(N - 1)) ? '0 : gi + 1'b1;
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_stream_arbiter.sv
// tb_sum_stream_arbiter: randomized and directed jobs against a queue scoreboard and a behavioural engine
module tb_sum_stream_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TO = 16;
  logic clk = 0;
  logic nrst = 0;
  always #5 clk = ~clk;
  logic [W-1:0] sd [N];
  logic sv [N];
  logic sl [N];
  logic [N*W-1:0] s_data;
  logic [N-1:0] s_valid, s_last, s_ready, r_valid, r_ready, grant;
  logic [W-1:0] r_data, eng_s_data, eng_sum;
  logic r_err, busy, eng_in_valid, eng_in_ready, eng_s_valid, eng_s_ready, eng_out_valid, eng_out_ready;
  always_comb
    for (int i = 0; i < N; i++) begin
      s_data[i*W +: W] = sd[i];
      s_valid[i] = sv[i];
      s_last[i] = sl[i];
    end
  sum_stream_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .r_data(r_data), .r_err(r_err), .r_valid(r_valid), .r_ready(r_ready), .grant(grant), .busy(busy),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_s_data(eng_s_data),
    .eng_s_valid(eng_s_valid), .eng_s_ready(eng_s_ready), .eng_out_valid(eng_out_valid),
    .eng_out_ready(eng_out_ready), .eng_sum(eng_sum));
  int n_chk = 0;
  int n_fail = 0;
  logic [W:0] exp_q [N][$];
  int served [$];
  bit hang = 0;
  bit bp = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic flag(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask
  // job expectation is the mod-2^W sum of its beats, or an error with zero data
  task automatic send(int i, int n, logic [31:0] b, bit to);
    logic [W-1:0] s;
    int c;
    bit a;
    s = '0;
    for (int k = 0; k < n; k++) s += b[k*8 +: 8];
    exp_q[i].push_back(to ? {1'b1, {W{1'b0}}} : {1'b0, s});
    for (int k = 0; k < n; k++) begin
      sd[i] = b[k*8 +: 8];
      sv[i] = 1;
      sl[i] = (k == n - 1);
      a = 0;
      c = 0;
      while (!a) begin
        @(negedge clk);
        a = s_ready[i];
        @(posedge clk);
        #1;
        if (++c > 2000) begin
          flag("send_beat");
          break;
        end
      end
    end
    sv[i] = 0;
    sl[i] = 0;
  endtask
  task automatic wait_done();
    int c = 0;
    while (busy || exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0 || exp_q[3].size() != 0) begin
      @(negedge clk);
      if (++c > 3000) begin
        flag("wait_done");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rnd_job(int i);
    if ($urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(i, $urandom_range(1, 4), $urandom, 0);
    end
  endtask
  // engine model: clears on start, sums accepted beats, answers some cycles into WAIT unless hung
  logic [W-1:0] acc;
  bit ov;
  int ph;
  logic [3:0] pat = 4'b1001;
  initial begin
    eng_in_ready = 0; eng_s_ready = 0; eng_out_valid = 0; eng_sum = '0;
    acc = '0; ov = 0; ph = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        acc = '0;
        ov = 0;
      end else begin
        if (eng_in_valid && eng_in_ready) acc = '0;
        if (eng_s_valid && eng_s_ready) acc += eng_s_data;
        if (eng_out_valid && eng_out_ready) ov = 0;
        else if (eng_out_ready && !hang && $urandom_range(0, 3) != 0) ov = 1;
      end
      @(posedge clk);
      #1;
      eng_in_ready = 1'($urandom_range(0, 1));
      eng_s_ready = bp ? pat[ph % 4] : ($urandom_range(0, 3) != 0);
      ph++;
      eng_out_valid = ov;
      eng_sum = acc;
    end
  end
  // monitor: round-robin reference, handshake rules, and scoreboard pops on result acceptance
  initial begin
    logic [N-1:0] pg, psv;
    logic [W:0] ev;
    int rrm, e;
    pg = '0; psv = '0; rrm = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        pg = '0;
        psv = '0;
        rrm = 0;
        continue;
      end
      if (grant != '0) chk("grant_onehot", 32'($onehot(grant)), 1);
      chk("s_ready_mask", s_ready & ~grant, 0);
      if (eng_s_valid) chk("s_ready_mirror", s_ready, eng_s_ready ? grant : '0);
      if (pg == '0 && grant != '0) begin
        e = -1;
        for (int k = N - 1; k >= 0; k--) if (psv[(rrm + k) % N]) e = (rrm + k) % N;
        chk("rr_grant", grant, (e < 0) ? 0 : (1 << e));
        chk("start_latency", eng_in_valid, 1);
      end
      if (r_valid != '0) begin
        chk("r_valid_owner", r_valid, grant);
        for (int i = 0; i < N; i++)
          if (r_valid[i] && r_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_result: requester %0d got %0h, none expected", i, r_data);
            end else begin
              ev = exp_q[i].pop_front();
              chk("r_data", r_data, ev[W-1:0]);
              chk("r_err", r_err, ev[W]);
            end
            rrm = (i + 1) % N;
            served.push_back(i);
          end
      end
      pg = grant;
      psv = s_valid;
    end
  end
  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    int n;
    logic [W-1:0] hd;
    logic he;
    for (int i = 0; i < N; i++) begin
      sd[i] = '0;
      sv[i] = 0;
      sl[i] = 0;
    end
    r_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    nrst = 1;
    // simultaneous requests from 0 and 2, then 0 again while 2 is pending
    fork
      begin
        send(0, 2, 32'h0101, 0);
        send(0, 2, 32'h0101, 0);
      end
      send(2, 2, 32'h0101, 0);
    join
    wait_done();
    chk("order_len", served.size(), 3);
    if (served.size() >= 3) begin
      chk("order_0", served[0], 0);
      chk("order_1", served[1], 2);
      chk("order_2", served[2], 0);
    end
    send(0, 4, 32'hFF030201, 0);
    wait_done();
    bp = 1;
    send(1, 3, 32'h060504, 0);
    wait_done();
    bp = 0;
    // engine never answers: abort after TO cycles in WAIT
    hang = 1;
    send(1, 1, 32'h07, 1);
    n = 0;
    @(negedge clk);
    while (eng_out_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_r_valid", r_valid, 4'b0010);
    wait_done();
    hang = 0;
    send(1, 1, 32'h03, 0);
    wait_done();
    // result stall on requester 3 while requester 0 waits
    r_ready[3] = 0;
    fork
      send(3, 2, 32'h0605, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        send(0, 1, 32'h02, 0);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!r_valid[3] && n < 500) begin
          n++;
          @(negedge clk);
        end
        chk("stall_r_valid", r_valid[3], 1);
        hd = r_data;
        he = r_err;
        repeat (5) begin
          @(negedge clk);
          chk("stall_data", r_data, hd);
          chk("stall_err", r_err, he);
          chk("stall_grant", grant, 4'b1000);
        end
        @(posedge clk);
        #1;
        r_ready[3] = 1;
      end
    join
    wait_done();
    // reset in the middle of a stream from requester 2
    sd[2] = 8'h40;
    sl[2] = 0;
    sv[2] = 1;
    n = 0;
    @(negedge clk);
    while (!eng_s_valid && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("pre_reset_grant", grant, 4'b0100);
    #2 nrst = 0;
    #1;
    chk("rst_ctrl", {s_ready, r_valid, grant, busy, eng_in_valid, eng_s_valid, eng_out_ready, r_err}, 0);
    chk("rst_data", {r_data, eng_s_data}, 0);
    sv[2] = 0;
    repeat (2) @(posedge clk);
    #1 nrst = 1;
    send(2, 1, 32'h09, 0);
    wait_done();
    for (int r = 0; r < 40; r++) begin
      fork
        rnd_job(0);
        rnd_job(1);
        rnd_job(2);
        rnd_job(3);
      join
      wait_done();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
